// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator: FSM state
// encoding, LFSR seed/tap mask and the default pattern.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed on register bits [15],[13],[12],[10]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [4:0]  DEF_PAT   = 5'b10101;

    function automatic logic lfsr_feedback(input logic [15:0] lfsr);
        return ^(lfsr & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/seq_gen_lfsr.sv
// 16-bit Fibonacci LFSR producing filler bits; only built when
// SEQ_GEN_LFSR_EN is defined.
module seq_gen_lfsr
    import seq_gen_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_out
);

    logic [15:0] lfsr_r;

    // LFSR shift register, seeded on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= LFSR_SEED;
        end else if (en) begin
            lfsr_r <= {lfsr_r[14:0], lfsr_feedback(lfsr_r)};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign bit_out = lfsr_r[15];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, rep_in+1
// times with GAP_CYC idle cycles between frames. Filler source selected by SEQ_GEN_LFSR_EN.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int PAT_W   = 5,
    parameter int GAP_CYC = 2,
    parameter int REP_W   = 8,
    localparam int LEN_W  = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic [REP_W-1:0] rep_in,
    output logic             data_out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t             state_r, state_s;
    logic [PAT_W-1:0]   pat_r, pat_s;
    logic [LEN_W-1:0]   len_r, len_s, len_clamp_s;
    logic [LEN_W-1:0]   bit_r, bit_s;
    logic [REP_W-1:0]   rem_r, rem_s;
    logic [GAP_W-1:0]   gap_r, gap_s;
    logic               filler_s;
    logic               data_s, valid_s, busy_s, done_s;

`ifdef SEQ_GEN_LFSR_EN
    seq_gen_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .en      (1'b1),
        .bit_out (filler_s)
    );
`else
    assign filler_s = 1'b0;
`endif

    // State and shadow/counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            pat_r   <= PAT_W'(DEF_PAT);
            len_r   <= '0;
            bit_r   <= '0;
            rem_r   <= '0;
            gap_r   <= '0;
        end else begin
            state_r <= state_s;
            pat_r   <= pat_s;
            len_r   <= len_s;
            bit_r   <= bit_s;
            rem_r   <= rem_s;
            gap_r   <= gap_s;
        end
    end

    // Clamp the requested length to the pattern register width
    always_comb begin
        if (len_in > LEN_W'(PAT_W)) begin
            len_clamp_s = LEN_W'(PAT_W);
        end else begin
            len_clamp_s = len_in;
        end
    end

    // Next-state and counter logic; rem_r counts frames still to send after the current one
    always_comb begin
        state_s = state_r;
        pat_s   = pat_r;
        len_s   = len_r;
        bit_s   = bit_r;
        rem_s   = rem_r;
        gap_s   = gap_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    pat_s = pat_in;
                    len_s = len_clamp_s;
                    rem_s = rep_in;
                    bit_s = len_clamp_s - LEN_W'(1);
                    if (len_clamp_s == LEN_W'(0)) begin
                        state_s = FIN;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (bit_r == LEN_W'(0)) begin
                    if (rem_r != REP_W'(0)) begin
                        if (GAP_CYC == 0) begin
                            state_s = SHIFT;
                            bit_s   = len_r - LEN_W'(1);
                            rem_s   = rem_r - REP_W'(1);
                        end else begin
                            state_s = GAP;
                            gap_s   = GAP_W'(GAP_CYC - 1);
                        end
                    end else begin
                        state_s = FIN;
                    end
                end else begin
                    bit_s = bit_r - LEN_W'(1);
                end
            end
            GAP: begin
                if (gap_r == GAP_W'(0)) begin
                    state_s = SHIFT;
                    bit_s   = len_r - LEN_W'(1);
                    rem_s   = rem_r - REP_W'(1);
                end else begin
                    gap_s = gap_r - GAP_W'(1);
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs register with latency 1
    always_comb begin
        valid_s = (state_s == SHIFT);
        busy_s  = (state_s == SHIFT) || (state_s == GAP);
        done_s  = (state_s == FIN);
        if (state_s == SHIFT) begin
            data_s = pat_s[bit_s];
        end else if ((state_s == IDLE) || (state_s == GAP)) begin
            data_s = filler_s;
        end else begin
            data_s = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            data_out <= data_s;
            valid    <= valid_s;
            busy     <= busy_s;
            done     <= done_s;
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen (default build, filler = 0); a second
// instance with GAP_CYC=0 feeds a reference 10101 detector model.
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start0;
    logic [4:0] pat_in;
    logic [2:0] len_in;
    logic [7:0] rep_in;
    logic       data_out, valid, busy, done;
    logic       data_out0, valid0, busy0, done0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_pattern_gen #(.PAT_W(5), .GAP_CYC(2), .REP_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pat_in(pat_in), .len_in(len_in),
        .rep_in(rep_in), .data_out(data_out), .valid(valid), .busy(busy), .done(done)
    );

    seq_pattern_gen #(.PAT_W(5), .GAP_CYC(0), .REP_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .pat_in(pat_in), .len_in(len_in),
        .rep_in(rep_in), .data_out(data_out0), .valid(valid0), .busy(busy0), .done(done0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check one cycle of dut outputs, then advance
    task automatic cyc(input string tag, input logic v, input logic d, input logic b, input logic dn);
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".data"},  32'(data_out), 32'(d));
        chk({tag, ".busy"},  32'(busy), 32'(b));
        chk({tag, ".done"},  32'(done), 32'(dn));
        step();
    endtask

    task automatic frame(input string tag, input logic [4:0] p, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cyc(tag, 1'b1, p[i], 1'b1, 1'b0);
        end
    endtask

    task automatic launch(input logic [4:0] p, input logic [2:0] l, input logic [7:0] r);
        pat_in = p;
        len_in = l;
        rep_in = r;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    initial begin
        int c, cnt, m, k;
        logic [4:0] w;
        rst = 1'b1; start = 1'b0; start0 = 1'b0;
        pat_in = 5'd0; len_in = 3'd0; rep_in = 8'd0;
        step();
        step();
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.busy",  32'(busy),  32'd0);
        chk("rst.done",  32'(done),  32'd0);
        chk("rst.data",  32'(data_out), 32'd0);
        chk("rst.valid0", 32'(valid0), 32'd0);
        rst = 1'b0;
        step();

        // Single frame
        launch(5'b10101, 3'd5, 8'd0);
        frame("s1", 5'b10101, 5);
        cyc("s1.fin", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("s1.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Two frames with a 2-cycle gap
        launch(5'b10101, 3'd5, 8'd1);
        frame("s2.f0", 5'b10101, 5);
        cyc("s2.gap", 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("s2.gap", 1'b0, 1'b0, 1'b1, 1'b0);
        frame("s2.f1", 5'b10101, 5);
        cyc("s2.fin", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("s2.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Short length: only bits 2..0 of 11011 -> 0,1,1
        launch(5'b11011, 3'd3, 8'd0);
        cyc("s3.b2", 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("s3.b1", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("s3.b0", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("s3.fin", 1'b0, 1'b0, 1'b0, 1'b1);

        // Re-start and input change mid-frame are ignored
        launch(5'b10101, 3'd5, 8'd0);
        cyc("s4", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("s4", 1'b1, 1'b0, 1'b1, 1'b0);
        start = 1'b1; pat_in = 5'b01010; len_in = 3'd2; rep_in = 8'd4;
        cyc("s4", 1'b1, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        cyc("s4", 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("s4", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("s4.fin", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("s4.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("s4.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame aborts immediately
        launch(5'b10101, 3'd5, 8'd0);
        cyc("s5", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("s5", 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk("s5.rst.valid", 32'(valid), 32'd0);
        chk("s5.rst.busy",  32'(busy),  32'd0);
        chk("s5.rst.data",  32'(data_out), 32'd0);
        chk("s5.rst.done",  32'(done),  32'd0);
        step();
        rst = 1'b0;
        step();
        cyc("s5.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("s5.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        launch(5'b10101, 3'd5, 8'd0);
        frame("s5.re", 5'b10101, 5);
        cyc("s5.re.fin", 1'b0, 1'b0, 1'b0, 1'b1);

        // Zero length goes straight to FIN
        launch(5'b11111, 3'd0, 8'd3);
        cyc("len0.fin", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("len0.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Oversize length clamps to 5
        launch(5'b10011, 3'd7, 8'd0);
        frame("clamp", 5'b10011, 5);
        cyc("clamp.fin", 1'b0, 1'b0, 1'b0, 1'b1);

        // Max repeat count: 256 one-bit frames, done at cycle 767
        launch(5'b00001, 3'd1, 8'd255);
        c = 1; cnt = 0;
        while (!done && c < 2000) begin
            if (valid) cnt++;
            step();
            c++;
        end
        chk("repmax.done_seen", 32'(done), 32'd1);
        chk("repmax.frames", 32'(cnt), 32'd256);
        chk("repmax.done_cyc", 32'(c), 32'd767);
        step();

        // Back-to-back frames into a non-overlapping 10101 detector model
        pat_in = 5'b10101; len_in = 3'd5; rep_in = 8'd3;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        c = 1; cnt = 0; m = 0; k = 0; w = 5'd0;
        while (!done0 && c < 100) begin
            if (valid0) begin
                cnt++;
                w = {w[3:0], data_out0};
                k++;
                if (k >= 5 && w == 5'b10101) begin
                    m++;
                    k = 0;
                end
            end
            step();
            c++;
        end
        chk("det.bits", 32'(cnt), 32'd20);
        chk("det.matches", 32'(m), 32'd4);
        chk("det.done_cyc", 32'(c), 32'd21);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
